// File: rtl/dfram_burst.sv
// rtl/dfram_burst.sv - byte-writable RAM with a flow-controlled burst-read streamer
//
// Purpose: entries are written with per-byte enables at any time; a burst
// request streams len consecutive entries (address wraps DEPTH-1 -> 0)
// through a 2-entry output FIFO with valid/ready handshaking.
//
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   wr_en, wr_addr, wr_data, wr_be    byte-masked write port
//   start, base_addr, len             burst request (accepted only when idle, len != 0)
//   abort                             cancel the active burst, no done pulse
//   out_valid, out_ready              output handshake
//   out_data, out_last                streamed entry, final-beat marker
//   busy, done                        engine active, one-cycle completion pulse
//   parity_err                        only with DFRAM_BURST_PARITY_EN: stored parity mismatch
//
// Optional feature macro: DFRAM_BURST_PARITY_EN (one even-parity bit per entry).
module dfram_burst #(
  parameter int DW    = 128,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH),
  parameter int LW    = AW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DW-1:0]   wr_data,
  input  logic [DW/8-1:0] wr_be,
  input  logic            start,
  input  logic [AW-1:0]   base_addr,
  input  logic [LW-1:0]   len,
  input  logic            abort,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic            out_last,
`ifdef DFRAM_BURST_PARITY_EN
  output logic            parity_err,
`endif
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t        r_state, w_state_nxt;
  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_addr;
  logic [LW-1:0] r_remain;
  logic          r_inflight;
  logic [DW-1:0] r_rd_data;
  logic          r_rd_last;
  logic [DW-1:0] r_fifo_data [2];
  logic [1:0]    r_fifo_last;
  logic          r_wptr, r_rptr;
  logic [1:0]    r_cnt;
  logic          w_pop, w_push, w_issue, w_flush, w_accept;
  logic [2:0]    w_level;

  // Memory write: merged per byte; reads elsewhere see the pre-write value
  // because they sample r_mem on the same edge.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < DW/8; i++) begin
        if (wr_be[i]) r_mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_accept    = 1'b0;
    done        = 1'b0;
    w_pop       = (r_cnt != 2'd0) && out_ready;
    w_flush     = abort && (r_state != S_IDLE);
    // The beat leaving this cycle frees a slot, so counting it keeps the
    // stream gap-free at one beat per cycle.
    w_level     = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    case (r_state)
      S_IDLE: begin
        if (start && !abort && (len != '0)) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_issue = (w_level < 3'd2);
          if (w_issue && (r_remain == LW'(1))) w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if ((r_cnt == 2'd0) && !r_inflight) begin
          done        = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_push = r_inflight && !w_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_remain    <= '0;
      r_inflight  <= 1'b0;
      r_rd_data   <= '0;
      r_rd_last   <= 1'b0;
      r_fifo_last <= 2'b00;
      r_wptr      <= 1'b0;
      r_rptr      <= 1'b0;
      r_cnt       <= 2'd0;
      for (int i = 0; i < 2; i++) r_fifo_data[i] <= '0;
    end else begin
      if (w_accept) begin
        r_addr   <= base_addr;
        r_remain <= len;
      end else if (w_issue) begin
        r_addr   <= (r_addr == AW'(DEPTH-1)) ? '0 : r_addr + AW'(1);
        r_remain <= r_remain - LW'(1);
      end
      r_inflight <= w_issue;
      if (w_issue) begin
        r_rd_data <= r_mem[r_addr];
        r_rd_last <= (r_remain == LW'(1));
      end
      if (w_flush) begin
        r_cnt  <= 2'd0;
        r_wptr <= 1'b0;
        r_rptr <= 1'b0;
      end else begin
        if (w_push) begin
          r_fifo_data[r_wptr] <= r_rd_data;
          r_fifo_last[r_wptr] <= r_rd_last;
          r_wptr              <= ~r_wptr;
        end
        if (w_pop) r_rptr <= ~r_rptr;
        r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
      end
    end
  end

  assign out_valid = (r_cnt != 2'd0);
  assign out_data  = out_valid ? r_fifo_data[r_rptr] : '0;
  assign out_last  = out_valid && r_fifo_last[r_rptr];
  assign busy      = (r_state != S_IDLE);

`ifdef DFRAM_BURST_PARITY_EN
  logic          r_par [DEPTH];
  logic [DW-1:0] w_wr_merged;
  logic          r_rd_perr;
  logic [1:0]    r_fifo_perr;

  // Parity covers the whole entry after the byte merge, not just new bytes.
  always_comb begin
    w_wr_merged = r_mem[wr_addr];
    for (int i = 0; i < DW/8; i++) begin
      if (wr_be[i]) w_wr_merged[8*i +: 8] = wr_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) r_par[wr_addr] <= ^w_wr_merged;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_perr   <= 1'b0;
      r_fifo_perr <= 2'b00;
    end else begin
      if (w_issue) r_rd_perr <= ((^r_mem[r_addr]) != r_par[r_addr]);
      if (w_push)  r_fifo_perr[r_wptr] <= r_rd_perr;
    end
  end

  assign parity_err = out_valid && r_fifo_perr[r_rptr];
`endif

endmodule

// File: doc/dfram_burst.md
DFRAM_BURST -- requirements
Module: dfram_burst

Interface
REQ-001 SHALL have parameter DW, default 128: data width per entry; a multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 1024: number of entries.
REQ-003 SHALL have parameter AW, default $clog2(DEPTH): address width.
REQ-004 SHALL have parameter LW, default AW+1: burst-length width.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on posedge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port wr_en, input, 1: write strobe.
REQ-008 SHALL have port wr_addr, input, AW: write address.
REQ-009 SHALL have port wr_data, input, DW: write data.
REQ-010 SHALL have port wr_be, input, DW/8: byte enables; bit i covers bits 8i+7..8i.
REQ-011 SHALL have port start, input, 1: burst request pulse.
REQ-012 SHALL have port base_addr, input, AW: burst start address.
REQ-013 SHALL have port len, input, LW: burst length in entries.
REQ-014 SHALL have port abort, input, 1: cancel the active burst.
REQ-015 SHALL have port out_valid, output, 1: out_data valid.
REQ-016 SHALL have port out_ready, input, 1: consumer accepts.
REQ-017 SHALL have port out_data, output, DW: streamed entry.
REQ-018 SHALL have port out_last, output, 1: final beat of the burst.
REQ-019 SHALL have port busy, output, 1: state is not IDLE.
REQ-020 SHALL have port done, output, 1: one-cycle pulse when a burst completes.

Function
REQ-021 SHALL write mem[wr_addr] on a clk edge with wr_en=1, updating only the bytes whose wr_be bit is 1; writes are legal in every state.
REQ-022 SHALL return pre-write data when a read and a write hit the same address in the same cycle.
REQ-023 SHALL use FSM IDLE -> RUN -> DRAIN -> IDLE.
REQ-024 SHALL accept start only in IDLE with len!=0, latching base_addr and len and entering RUN; start in IDLE with len=0 is ignored; start in RUN or DRAIN is ignored.
REQ-025 SHALL issue one synchronous read per RUN cycle when (FIFO occupancy + in-flight reads) < 2; read data enters a 2-entry output FIFO one cycle after issue.
REQ-026 SHALL increment the read address after each issue, wrapping from DEPTH-1 to 0.
REQ-027 SHALL enter DRAIN after issuing len reads, and leave DRAIN for IDLE when the FIFO is empty and no read is in flight, asserting done for that one cycle.
REQ-028 SHALL assert out_valid while the FIFO is non-empty; a beat transfers when out_valid and out_ready are both 1; out_data and out_last stay stable while out_valid=1 and out_ready=0.
REQ-029 SHALL assert out_last only with the len-th beat.
REQ-030 SHALL assert out_valid 2 cycles after the start edge when out_ready=1, then sustain 1 beat/cycle with no bubbles.
REQ-031 SHALL, on abort=1 in RUN or DRAIN, flush the FIFO, drop any in-flight read and enter IDLE on the next edge without done; abort in IDLE has no effect; abort outranks start in the same cycle.

Reset
REQ-032 SHALL, on rst=1 (asynchronous), force IDLE, empty the FIFO, and drive out_valid=0, out_last=0, busy=0, done=0, out_data=0; memory contents are not reset.
REQ-033 SHALL discard a burst interrupted by reset mid-operation; no beats are emitted after reset deasserts until a new start.

Configuration
REQ-034 SHALL, with macro DFRAM_BURST_PARITY_EN defined, store one even-parity bit per entry (over the written data, recomputed on byte-enable writes) and add output port parity_err (1 bit), valid with out_data, set to 1 on mismatch; parity_err resets to 0.
REQ-035 SHALL, without DFRAM_BURST_PARITY_EN, have no parity storage and no parity_err port.

Verification
REQ-036 Write 0xA5.. to addr 3..6, start base=3 len=4, out_ready=1 -> 4 beats, out_valid at cycle 2, out_last on beat 4, done 1 cycle later.
REQ-037 DEPTH=16, start base=14 len=4 -> data read from addresses 14,15,0,1 in order.
REQ-038 len=8, out_ready toggled 1/0 each cycle -> 8 beats, no loss or duplication, data held stable while stalled.
REQ-039 wr_be=0x0001 writes 0xFF to an entry holding 0 -> readback shows only byte 0 = 0xFF.
REQ-040 abort after 2 beats of a len=8 burst -> out_valid=0 and busy=0 next cycle, no done; rst asserted mid-burst -> all outputs 0 immediately.
